input_decimator: RTL

- Front-end conditioning stage that sits directly upstream of the network core.
- Captures samples on rising edges of the codec sample clock and averages blocks of 2^DECIM_LOG2 consecutive samples.
- Emits one decimated sample per block, together with a one-cycle strobe and a stretched rising-edge clock (out_clk), so the downstream core runs at the reduced rate with lower-variance input.

---
 rtl/input_decimator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/input_decimator.sv
// input_decimator: block-average decimator between the codec and the network core.
// Captures sample_in on each rising edge of sample_clk and averages blocks of
// 2**DECIM_LOG2 samples. Each block produces one sample_out, a one-cycle
// out_strobe and an out_clk pulse PULSE_CYCLES cycles long.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sample_clk  codec sample clock (synchronous to clk); rising edge = valid sample_in
//   sample_in   signed sample, W bits
//   flush       synchronous clear of the partial block
//   sample_out  signed decimated sample, held between updates
//   out_strobe  one-cycle pulse when sample_out updates
//   out_clk     stretched rising-edge clock for the next stage
//   block_count samples accumulated in the current block
//
// Optional macro DECIM_ROUND_EN: when defined, both shifts round half-up.
// When undefined, both shifts are plain arithmetic (floor) shifts.
module input_decimator #(
    parameter int unsigned W            = 16,
    parameter int unsigned DECIM_LOG2   = 2,
    parameter int unsigned OUT_SHIFT    = 0,
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_clk,
    input  logic [W-1:0]          sample_in,
    input  logic                  flush,
    output logic [W-1:0]          sample_out,
    output logic                  out_strobe,
    output logic                  out_clk,
    output logic [DECIM_LOG2:0]   block_count
);

    localparam int unsigned AW    = W + DECIM_LOG2;
    localparam int unsigned CW    = DECIM_LOG2 + 1;
    localparam int unsigned DECIM = 1 << DECIM_LOG2;
    localparam int unsigned PW    = $clog2(PULSE_CYCLES + 1);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t                state;
    logic                  prev_sc;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  samp_ext;
    logic signed [AW-1:0]  acc_next;
    logic [PW-1:0]         pulse_cnt;
    logic [PW-1:0]         pulse_next;
    logic                  sc_rise;
    logic                  last_c;
    logic                  emit_c;
    logic [W-1:0]          result;

    // Edge detect and block-completion decode
    assign sc_rise  = sample_clk & ~prev_sc;
    assign samp_ext = AW'($signed(sample_in));
    assign acc_next = acc + samp_ext;
    assign last_c   = (block_count == CW'(DECIM - 1));
    assign emit_c   = (state == ACCUM) && !flush && sc_rise && last_c;

    // Output value of the block that completes with the current sample
`ifdef DECIM_ROUND_EN
    localparam int unsigned RB_AVG = (2 ** DECIM_LOG2) / 2;
    localparam int unsigned RB_OUT = (2 ** OUT_SHIFT) / 2;

    logic signed [AW:0]   avg_sum;
    logic signed [AW:0]   avg_val;
    logic signed [AW+1:0] out_sum;

    // One extra bit per rounding adder so the bias can never wrap
    assign avg_sum = (AW+1)'(acc_next) + $signed((AW+1)'(RB_AVG));
    assign avg_val = avg_sum >>> DECIM_LOG2;
    assign out_sum = (AW+2)'(avg_val) + $signed((AW+2)'(RB_OUT));
    assign result  = W'(out_sum >>> OUT_SHIFT);
`else
    assign result  = W'((acc_next >>> DECIM_LOG2) >>> OUT_SHIFT);
`endif

    // out_clk stretch counter; a new emit reloads it
    always_comb begin
        pulse_next = pulse_cnt;
        if (emit_c) begin
            pulse_next = PW'(PULSE_CYCLES);
        end else if (pulse_cnt != '0) begin
            pulse_next = pulse_cnt - PW'(1);
        end
    end

    // Accumulate / emit state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            prev_sc     <= 1'b0;
            acc         <= '0;
            block_count <= '0;
            pulse_cnt   <= '0;
            sample_out  <= '0;
            out_strobe  <= 1'b0;
            out_clk     <= 1'b0;
        end else begin
            prev_sc    <= sample_clk;
            out_strobe <= 1'b0;
            pulse_cnt  <= pulse_next;
            out_clk    <= (pulse_next != '0);
            case (state)
                ACCUM: begin
                    if (flush) begin
                        acc         <= '0;
                        block_count <= '0;
                    end else if (sc_rise) begin
                        if (last_c) begin
                            // Block complete: publish now, restart in EMIT
                            sample_out  <= result;
                            out_strobe  <= 1'b1;
                            block_count <= '0;
                            state       <= EMIT;
                        end else begin
                            acc         <= acc_next;
                            block_count <= block_count + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    // A coincident edge seeds the next block unless flushed
                    if (sc_rise && !flush) begin
                        acc         <= samp_ext;
                        block_count <= CW'(1);
                    end else begin
                        acc         <= '0;
                        block_count <= '0;
                    end
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
